// File: rtl/l2_bus_pkg.sv
// Shared types and constants for the L2 bus arbiter: FSM states, port count,
// burst length and the per-port request bundle.
package l2_bus_pkg;

    localparam int L2_NUM_PORTS = 2;
    localparam int L2_BURST_LEN = 4;
    localparam int L2_AW        = 32;
    localparam int L2_DW        = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR
    } arb_state_e;

    typedef struct packed {
        logic              rd_en;
        logic              wr_en;
        logic [L2_AW-1:0]  addr;
        logic [L2_DW-1:0]  wr_data;
    } l2_req_t;

    function automatic logic [L2_NUM_PORTS-1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin pick: the port named by rr_ptr_i wins a
// tie, and a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o,
    output logic       vld_o
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[rr_ptr_i]) begin
            gnt_o[rr_ptr_i] = 1'b1;
        end else if (req_i[~rr_ptr_i]) begin
            gnt_o[~rr_ptr_i] = 1'b1;
        end
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/l2_bus_arbiter.sv
// Shares the L2 port between the I-cache (port 0) and D-cache (port 1) miss
// handlers: 4-beat refill read bursts and single-beat write-through writes.
module l2_bus_arbiter
    import l2_bus_pkg::*;
#(
    parameter int NUM_PORTS = L2_NUM_PORTS,
    parameter int BURST_LEN = L2_BURST_LEN,
    parameter int AW        = L2_AW,
    parameter int DW        = L2_DW
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req_rd_en,
    input  logic [NUM_PORTS-1:0]           req_wr_en,
    input  logic [NUM_PORTS-1:0][AW-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0][DW-1:0]   req_wr_data,
    output logic [NUM_PORTS-1:0]           rd_granted,
    output logic [NUM_PORTS-1:0]           wr_granted,
    output logic [DW-1:0]                  rd_data,
    output logic [NUM_PORTS-1:0]           rd_data_vld,
    output logic [AW-1:0]                  l2_addr,
    output logic                           l2_rd_en,
    output logic                           l2_wr_en,
    output logic [DW-1:0]                  l2_wr_data,
    input  logic [DW-1:0]                  l2_rd_data,
    input  logic                           l2_ready
);

    localparam int BW = $clog2(BURST_LEN);

    arb_state_e            state_q;
    logic                  owner_q;
    logic                  rr_ptr_q;
    logic [BW-1:0]         beat_cnt_q;
    logic [DW-1:0]         rd_data_q;
    logic [NUM_PORTS-1:0]  rd_data_vld_q;

    l2_req_t               own_req;
    logic [NUM_PORTS-1:0]  arb_req;
    logic [NUM_PORTS-1:0]  arb_gnt;
    logic                  arb_vld;
    logic                  wr_class;
    logic                  rd_fire;
    logic                  wr_fire;

    // Writes beat reads, so the arbiter only looks at the read class when no write is pending.
    assign wr_class = |req_wr_en;
    assign arb_req  = wr_class ? req_wr_en : req_rd_en;

    rr_arb2 u_rr_arb2 (
        .req_i    (arb_req),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (arb_gnt),
        .vld_o    (arb_vld)
    );

    always_comb begin
        own_req.rd_en   = req_rd_en[owner_q];
        own_req.wr_en   = req_wr_en[owner_q];
        own_req.addr    = req_addr[owner_q];
        own_req.wr_data = req_wr_data[owner_q];
    end

    assign rd_fire = (state_q == RD_BURST) && own_req.rd_en && l2_ready;
    assign wr_fire = (state_q == WR) && own_req.wr_en && l2_ready;

    always_comb begin
        l2_rd_en   = 1'b0;
        l2_wr_en   = 1'b0;
        l2_addr    = '0;
        l2_wr_data = '0;
        rd_granted = '0;
        wr_granted = '0;
        case (state_q)
            RD_BURST: begin
                l2_rd_en   = own_req.rd_en;
                l2_addr    = own_req.addr;
                rd_granted = rd_fire ? port_onehot(owner_q) : '0;
            end
            WR: begin
                l2_wr_en   = own_req.wr_en;
                l2_addr    = own_req.addr;
                l2_wr_data = own_req.wr_data;
                wr_granted = wr_fire ? port_onehot(owner_q) : '0;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every register here is
    // small enough to sit in the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            rr_ptr_q      <= 1'b0;
            beat_cnt_q    <= '0;
            rd_data_q     <= '0;
            rd_data_vld_q <= '0;
        end else begin
            rd_data_vld_q <= rd_granted;
            if (rd_fire) begin
                rd_data_q <= l2_rd_data;
            end
            case (state_q)
                IDLE: begin
                    if (arb_vld) begin
                        owner_q <= (arb_gnt == 2'b10);
                        state_q <= wr_class ? WR : RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (!own_req.rd_en) begin
                        state_q    <= IDLE;
                        rr_ptr_q   <= ~owner_q;
                        beat_cnt_q <= '0;
                    end else if (l2_ready) begin
                        beat_cnt_q <= beat_cnt_q + BW'(1);
                        if (beat_cnt_q == BW'(BURST_LEN - 1)) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= ~owner_q;
                        end
                    end
                end
                WR: begin
                    // Leave on the grant, or at once if the requester withdrew before it.
                    if (!own_req.wr_en || l2_ready) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= ~owner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_data_vld = rd_data_vld_q;

endmodule
